// File: rtl/inst_loader.sv
// Byte-stream program loader: takes a 4-byte little-endian word count, then MSB-first
// 64-bit instructions, writes them to instruction BRAM and holds the CPU until the image is in.
module inst_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [63:0]       imem_din,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {HDR, BODY, WRITE, DONE, ERR} state_t;

    localparam logic [32:0] MAX_COUNT = 33'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [31:0]       count_q, count_d;
    logic [ADDR_W:0]   index_q, index_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [63:0]       word_q, word_d;
    logic [7:0]        checksum_q, checksum_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [63:0]       imem_din_q, imem_din_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [5:0]        byte_pos;
    logic [ADDR_W:0]   index_inc;

    assign accept    = rx_valid && rx_ready_q && !restart;
    // MSB first: byte 0 lands at bit 56, byte 7 at bit 0
    assign byte_pos  = {~byte_cnt_q, 3'b000};
    assign index_inc = index_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        index_d     = index_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        checksum_d  = checksum_q;
        imem_addr_d = imem_addr_q;
        imem_din_d  = imem_din_q;

        if (restart) begin
            state_d    = HDR;
            count_d    = '0;
            index_d    = '0;
            byte_cnt_d = '0;
            word_d     = '0;
            checksum_d = '0;
        end else begin
            if (accept) begin
                checksum_d = checksum_q + rx_data;
            end
            case (state_q)
                HDR: begin
                    if (accept) begin
                        count_d    = {rx_data, count_q[31:8]};
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_d = '0;
                            index_d    = '0;
                            if (count_d == 32'd0) begin
                                state_d = DONE;
                            end else if ({1'b0, count_d} > MAX_COUNT) begin
                                state_d = ERR;
                            end else begin
                                state_d = BODY;
                            end
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        word_d[byte_pos +: 8] = rx_data;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd7) begin
                            byte_cnt_d  = '0;
                            state_d     = WRITE;
                            imem_din_d  = word_d;
                            imem_addr_d = index_q[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    index_d = index_inc;
                    // index is one bit wider than the address so a full image never wraps
                    if (33'(index_inc) == {1'b0, count_q}) begin
                        state_d = DONE;
                    end else begin
                        state_d = BODY;
                    end
                end
                default: ;
            endcase
        end

        rx_ready_d = (state_d == HDR) || (state_d == BODY);
        imem_we_d  = (state_d == WRITE);
        cpu_hold_d = (state_d != DONE);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HDR;
            count_q     <= '0;
            index_q     <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            checksum_q  <= '0;
            rx_ready_q  <= 1'b1;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_din_q  <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            checksum_q  <= checksum_d;
            rx_ready_q  <= rx_ready_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_din_q  <= imem_din_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_din  = imem_din_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err       = err_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader (ADDR_W=4 so the capacity and oversize-header
// boundaries are reachable in a short run).
module tb_inst_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          restart = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [63:0]   imem_din;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [7:0]    checksum;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;
    int wr_n = 0;
    logic [AW-1:0] wr_addr [0:63];
    logic [63:0]   wr_din  [0:63];

    inst_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_din(imem_din), .cpu_hold(cpu_hold),
        .done(done), .err(err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture every write strobe; a strobe must always coincide with rx_ready low.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = imem_addr;
                wr_din[wr_n]  = imem_din;
            end
            wr_n++;
            check("ready_low_in_write", {63'd0, rx_ready}, 64'd0);
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 20) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        if (!rx_ready) check("handshake_timeout", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;
        if (gap) rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] cnt, input bit gap);
        for (int i = 0; i < 4; i++) send(cnt[8*i +: 8], gap);
    endtask

    task automatic send_word(input logic [63:0] w, input bit gap);
        for (int i = 7; i >= 0; i--) send(w[8*i +: 8], gap);
    endtask

    task automatic pulse_restart(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        restart  = 1'b1;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic check_finish(input string tag);
        @(negedge clk);
        check({tag, "_we"},   {63'd0, imem_we},  64'd1);
        check({tag, "_done0"}, {63'd0, done},    64'd0);
        @(negedge clk);
        check({tag, "_we_off"}, {63'd0, imem_we}, 64'd0);
        check({tag, "_done"},   {63'd0, done},    64'd1);
        check({tag, "_hold"},   {63'd0, cpu_hold}, 64'd0);
        check({tag, "_ready"},  {63'd0, rx_ready}, 64'd0);
    endtask

    initial begin
        // 1: reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, rx_ready}, 64'd1);
        check("rst_hold",  {63'd0, cpu_hold}, 64'd1);
        check("rst_done",  {63'd0, done},     64'd0);
        check("rst_err",   {63'd0, err},      64'd0);
        check("rst_we",    {63'd0, imem_we},  64'd0);
        check("rst_csum",  {56'd0, checksum}, 64'd0);
        $display("step reset: ready=%0b hold=%0b", rx_ready, cpu_hold);

        // 2: two words with idle gaps
        wr_n = 0;
        send_hdr(32'd2, 1'b1);
        send_word(64'h0102030405060708, 1'b1);
        send_word(64'h1112131415161718, 1'b1);
        check_finish("t2");
        check("t2_nwr",  wr_n, 2);
        check("t2_a0",   {60'd0, wr_addr[0]}, 64'd0);
        check("t2_d0",   wr_din[0], 64'h0102030405060708);
        check("t2_a1",   {60'd0, wr_addr[1]}, 64'd1);
        check("t2_d1",   wr_din[1], 64'h1112131415161718);
        check("t2_csum", {56'd0, checksum}, 64'h00000000000000CA);
        $display("step two-word load: writes=%0d checksum=%h", wr_n, checksum);

        // restart from DONE
        pulse_restart(8'h00);
        @(negedge clk);
        check("rs1_done",  {63'd0, done},     64'd0);
        check("rs1_hold",  {63'd0, cpu_hold}, 64'd1);
        check("rs1_ready", {63'd0, rx_ready}, 64'd1);
        check("rs1_csum",  {56'd0, checksum}, 64'd0);

        // 3: empty image; bytes in DONE are refused
        wr_n = 0;
        send_hdr(32'd0, 1'b1);
        @(negedge clk);
        check("t3_done", {63'd0, done},     64'd1);
        check("t3_hold", {63'd0, cpu_hold}, 64'd0);
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        check("t3_nwr",  wr_n, 0);
        check("t3_csum", {56'd0, checksum}, 64'd0);
        $display("step empty image: done=%0b writes=%0d", done, wr_n);
        pulse_restart(8'h00);

        // 4: oversize header (17 > 16)
        send_hdr(32'd17, 1'b1);
        @(negedge clk);
        check("t4_err",   {63'd0, err},      64'd1);
        check("t4_ready", {63'd0, rx_ready}, 64'd0);
        check("t4_hold",  {63'd0, cpu_hold}, 64'd1);
        check("t4_csum",  {56'd0, checksum}, 64'h11);
        repeat (3) @(negedge clk);
        check("t4_err_held", {63'd0, err}, 64'd1);
        check("t4_nwr", wr_n, 0);
        pulse_restart(8'h33);
        @(negedge clk);
        check("t4_err_clr", {63'd0, err},      64'd0);
        check("t4_ready1",  {63'd0, rx_ready}, 64'd1);
        check("t4_csum0",   {56'd0, checksum}, 64'd0);
        $display("step oversize header: err cleared=%0b", !err);

        // 5: continuous valid, one stall per WRITE between words
        wr_n = 0;
        send_hdr(32'd2, 1'b0);
        stall_cnt = 0;
        send_word(64'h0102030405060708, 1'b0);
        send_word(64'h1112131415161718, 1'b0);
        check("t5_stalls", stall_cnt, 1);
        check_finish("t5");
        rx_valid = 1'b0;
        check("t5_nwr", wr_n, 2);
        check("t5_d0",  wr_din[0], 64'h0102030405060708);
        check("t5_d1",  wr_din[1], 64'h1112131415161718);
        check("t5_csum", {56'd0, checksum}, 64'h00000000000000CA);
        $display("step streaming load: stalls=%0d writes=%0d", stall_cnt, wr_n);
        pulse_restart(8'h00);

        // full capacity: 16 words, bytes 0..127
        wr_n = 0;
        send_hdr(32'd16, 1'b0);
        for (int w = 0; w < 16; w++) begin
            logic [63:0] v;
            for (int k = 0; k < 8; k++) v[8*(7-k) +: 8] = 8'(w*8 + k);
            send_word(v, 1'b0);
        end
        check_finish("cap");
        rx_valid = 1'b0;
        check("cap_nwr",  wr_n, 16);
        check("cap_alast", {60'd0, wr_addr[15]}, 64'd15);
        check("cap_dlast", wr_din[15], 64'h78797A7B7C7D7E7F);
        check("cap_err",  {63'd0, err}, 64'd0);
        check("cap_csum", {56'd0, checksum}, 64'hD0);
        $display("step full capacity: writes=%0d last addr=%0d", wr_n, wr_addr[15]);
        pulse_restart(8'h00);

        // 6: asynchronous reset after 5 body bytes
        wr_n = 0;
        send_hdr(32'd3, 1'b1);
        for (int i = 0; i < 5; i++) send(8'(8'hC0 + i), 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_ready", {63'd0, rx_ready}, 64'd1);
        check("t6_hold",  {63'd0, cpu_hold}, 64'd1);
        check("t6_csum",  {56'd0, checksum}, 64'd0);
        check("t6_din",   imem_din, 64'd0);
        check("t6_done",  {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_hdr(32'd1, 1'b1);
        send_word(64'hA1A2A3A4A5A6A7A8, 1'b1);
        check_finish("t6");
        check("t6_nwr",  wr_n, 1);
        check("t6_a0",   {60'd0, wr_addr[0]}, 64'd0);
        check("t6_d0",   wr_din[0], 64'hA1A2A3A4A5A6A7A8);
        check("t6_csum2", {56'd0, checksum}, 64'h25);
        $display("step async reset reload: writes=%0d checksum=%h", wr_n, checksum);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
